microcode_sequencer: RTL
========================

MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 Parameter INSN_W, default 8: instruction register width.
REQ-002 Parameter OPCODE_W, default 4: opcode width; opcode = insn[INSN_W-1 -: OPCODE_W]; OPCODE_W <= INSN_W.
REQ-003 Parameter MAX_STEPS, default 5: T-states per instruction, legal range 5..16; STEP_W = clog2(MAX_STEPS).
REQ-004 clk  input  1  the only clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 insn  input  INSN_W  current instruction register contents.
REQ-007 step_en  input  1  advance enable; low freezes the sequencer (single-step support).
REQ-008 carry_flag, zero_flag  input  1 each  registered ALU flags.
REQ-009 hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j, fi  output  1 each  control strobes.
REQ-010 step  output  STEP_W  current T-state.
REQ-011 done  output  1  high during the last T-state of the current instruction.

Function
REQ-012 State: step register, halted flag; all outputs are a combinational decode of (step, opcode, flags, halted, step_en).
REQ-013 T0: mi, co. T1: ro, ii, ce. These apply to every opcode.
REQ-014 Opcode codes (zero-extended to OPCODE_W): NOP=0, LDA=1, ADD=2, SUB=3, STA=4, LDI=5, JMP=6, JC=7, JZ=8, OUT=14, HLT=15.
- For OPCODE_W > 4, OUT and HLT are all-ones-minus-one and all-ones respectively.
REQ-015 LDA: T2 io,mi; T3 ro,ai; last step T3.
REQ-016 ADD: T2 io,mi; T3 ro,bi; T4 sumo,ai,fi; last step T4. SUB: same as ADD, with sub also high at T4.
REQ-017 STA: T2 io,mi; T3 ao,ri; last step T3.
REQ-018 LDI: T2 io,ai; last step T2.
REQ-019 JMP: T2 io,j; last step T2.
REQ-020 JC: T2 io,j only if carry_flag=1, else no strobes; last step T2.
REQ-021 JZ: the same rule as JC, using zero_flag.
- Flags are sampled combinationally during T2.
REQ-022 OUT: T2 ao,oi; last step T2.
REQ-023 HLT: T2 hlt; last step T2.
REQ-024 NOP and every undefined opcode: T2 no strobes; last step T2.
REQ-025 On a clock edge with step_en=1:
- If done=1 or step=MAX_STEPS-1, step becomes 0.
- Otherwise step increments by 1.
- Variable-length instructions terminate early; T-states beyond the last step are never entered.
REQ-026 On a clock edge with step_en=0, step and halted hold their values.
REQ-027 While step_en=0, all strobes except hlt are 0.
REQ-028 HLT at T2 with step_en=1 sets halted on that edge.
REQ-029 While halted=1:
- hlt=1 and all other strobes are 0.
- done=0.
- step is frozen at 0, regardless of step_en.
REQ-030 Only reset clears halted.
REQ-031 insn changing mid-instruction takes effect combinationally; the environment keeps insn stable from the T1 edge until done.

Reset
REQ-032 rst=0 sampled on a rising edge: step=0 and halted=0, overriding step_en and halt.
REQ-033 While rst=0, outputs decode T0: mi=1, co=1, all other strobes 0, done=0.
REQ-034 Reset asserted mid-instruction or while halted aborts it; the first cycle after release is T0.

Verification
REQ-035 Reset, then insn=0x1A (LDA), step_en=1 -> T0 mi,co; T1 ro,ii,ce; T2 io,mi; T3 ro,ai with done=1; the next cycle is T0.
REQ-036 insn=0x2F (ADD), 5 cycles -> T4 sumo,ai,fi, done=1; insn=0x3F (SUB) -> same sequence with sub=1 at T4; step wraps to 0 after T4.
REQ-037 insn=0x70 (JC), two passes:
- carry_flag=0 -> T2 no strobes, done=1.
- carry_flag=1 -> T2 io,j.
- Repeat with JZ (0x80) and zero_flag.
REQ-038 insn=0xF0 (HLT) -> T2 hlt; afterwards hlt stays 1 and step stays 0 for 20 cycles with step_en toggling; rst=0 for one cycle -> T0 mi,co.
REQ-039 ADD in progress, step_en=0 for 3 cycles at T3 -> step holds 3 and strobes are 0; re-enable -> T3 strobes, then T4.
REQ-040 rst=0 at T3 of STA -> next cycle T0; repeat with INSN_W=12, OPCODE_W=6, MAX_STEPS=8 -> HLT is 0x3F, and the LDA sequence is unchanged.

Source files
------------

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - T-state microcode sequencer with halt and single-step
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   insn        instruction register; opcode is the top OPCODE_W bits
//   step_en     advance enable; low freezes the sequencer
//   carry_flag  registered ALU carry, consulted by JC at T2
//   zero_flag   registered ALU zero, consulted by JZ at T2
//   hlt..fi     control strobes, combinational decode of the current T-state
//   step        current T-state
//   done        high during the last T-state of the current instruction
module microcode_sequencer #(
    parameter int INSN_W    = 8,
    parameter int OPCODE_W  = 4,
    parameter int MAX_STEPS = 5,
    localparam int STEP_W   = $clog2(MAX_STEPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INSN_W-1:0] insn,
    input  logic              step_en,
    input  logic              carry_flag,
    input  logic              zero_flag,
    output logic              hlt,
    output logic              mi,
    output logic              ri,
    output logic              ro,
    output logic              io,
    output logic              ii,
    output logic              ai,
    output logic              ao,
    output logic              sumo,
    output logic              sub,
    output logic              bi,
    output logic              oi,
    output logic              ce,
    output logic              co,
    output logic              j,
    output logic              fi,
    output logic [STEP_W-1:0] step,
    output logic              done
);

    // Bit positions in the internal control word.
    localparam int B_HLT  = 15;
    localparam int B_MI   = 14;
    localparam int B_RI   = 13;
    localparam int B_RO   = 12;
    localparam int B_IO   = 11;
    localparam int B_II   = 10;
    localparam int B_AI   = 9;
    localparam int B_AO   = 8;
    localparam int B_SUMO = 7;
    localparam int B_SUB  = 6;
    localparam int B_BI   = 5;
    localparam int B_OI   = 4;
    localparam int B_CE   = 3;
    localparam int B_CO   = 2;
    localparam int B_J    = 1;
    localparam int B_FI   = 0;

    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_HLT = '1;
    localparam logic [OPCODE_W-1:0] OP_OUT = OP_HLT - OPCODE_W'(1);

    localparam logic [STEP_W-1:0] T2     = STEP_W'(2);
    localparam logic [STEP_W-1:0] T3     = STEP_W'(3);
    localparam logic [STEP_W-1:0] T4     = STEP_W'(4);
    localparam logic [STEP_W-1:0] T_LAST = STEP_W'(MAX_STEPS - 1);

    logic [STEP_W-1:0]   step_q;
    logic                halted_q;
    logic [OPCODE_W-1:0] opcode;
    logic [STEP_W-1:0]   eff_step;
    logic                eff_halted;
    logic                en;
    logic [STEP_W-1:0]   last_step;
    logic [15:0]         ctl;
    logic                unused_insn;

    assign opcode      = insn[INSN_W-1 -: OPCODE_W];
    assign unused_insn = ^insn;

    // While reset is held the outputs already present T0, so the state
    // is masked here rather than waiting for the reset edge.
    assign eff_step   = rst ? step_q : '0;
    assign eff_halted = rst & halted_q;
    assign en         = step_en | ~rst;

    always_comb begin
        ctl       = '0;
        done      = 1'b0;
        last_step = T2;

        case (opcode)
            OP_LDA, OP_STA: last_step = T3;
            OP_ADD, OP_SUB: last_step = T4;
            default:        last_step = T2;
        endcase

        if (eff_halted) begin
            ctl[B_HLT] = 1'b1;
        end else begin
            done = (eff_step == last_step);
            case (eff_step)
                STEP_W'(0): begin
                    ctl[B_MI] = 1'b1;
                    ctl[B_CO] = 1'b1;
                end
                STEP_W'(1): begin
                    ctl[B_RO] = 1'b1;
                    ctl[B_II] = 1'b1;
                    ctl[B_CE] = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctl[B_IO] = 1'b1;
                            ctl[B_MI] = 1'b1;
                        end
                        OP_LDI: begin
                            ctl[B_IO] = 1'b1;
                            ctl[B_AI] = 1'b1;
                        end
                        OP_JMP: begin
                            ctl[B_IO] = 1'b1;
                            ctl[B_J]  = 1'b1;
                        end
                        OP_JC: begin
                            ctl[B_IO] = carry_flag;
                            ctl[B_J]  = carry_flag;
                        end
                        OP_JZ: begin
                            ctl[B_IO] = zero_flag;
                            ctl[B_J]  = zero_flag;
                        end
                        OP_OUT: begin
                            ctl[B_AO] = 1'b1;
                            ctl[B_OI] = 1'b1;
                        end
                        OP_HLT: ctl[B_HLT] = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ctl[B_RO] = 1'b1;
                            ctl[B_AI] = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctl[B_RO] = 1'b1;
                            ctl[B_BI] = 1'b1;
                        end
                        OP_STA: begin
                            ctl[B_AO] = 1'b1;
                            ctl[B_RI] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        ctl[B_SUMO] = 1'b1;
                        ctl[B_AI]   = 1'b1;
                        ctl[B_FI]   = 1'b1;
                        ctl[B_SUB]  = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
            // Single-step freeze: hlt stays visible so a paused HLT is still seen.
            if (!en) begin
                ctl = ctl & 16'h8000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            step_q   <= '0;
            halted_q <= 1'b0;
        end else if (halted_q) begin
            step_q <= '0;
        end else if (step_en) begin
            if (done || step_q == T_LAST) begin
                step_q <= '0;
            end else begin
                step_q <= step_q + STEP_W'(1);
            end
            if (step_q == T2 && opcode == OP_HLT) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign step = eff_step;
    assign hlt  = ctl[B_HLT];
    assign mi   = ctl[B_MI];
    assign ri   = ctl[B_RI];
    assign ro   = ctl[B_RO];
    assign io   = ctl[B_IO];
    assign ii   = ctl[B_II];
    assign ai   = ctl[B_AI];
    assign ao   = ctl[B_AO];
    assign sumo = ctl[B_SUMO];
    assign sub  = ctl[B_SUB];
    assign bi   = ctl[B_BI];
    assign oi   = ctl[B_OI];
    assign ce   = ctl[B_CE];
    assign co   = ctl[B_CO];
    assign j    = ctl[B_J];
    assign fi   = ctl[B_FI];

endmodule
